// File: rtl/ekf_pkg.sv
// Shared definitions for the EKF-SLAM stage sequencer: stage codes,
// error code bits, sequencer state encoding and a stage-code check.
package ekf_pkg;

  localparam int STAGE_W = 3;

  localparam logic [STAGE_W-1:0] IDLE        = 3'd0;
  localparam logic [STAGE_W-1:0] STAGE_PRD   = 3'd1;
  localparam logic [STAGE_W-1:0] STAGE_NEW   = 3'd2;
  localparam logic [STAGE_W-1:0] STAGE_UPD   = 3'd3;
  localparam logic [STAGE_W-1:0] STAGE_ASSOC = 3'd4;

  localparam logic [1:0] ERR_TMO = 2'b01;
  localparam logic [1:0] ERR_ILL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } seq_state_e;

  // Only PRD..ASSOC may be sent to the Top; IDLE and codes above ASSOC are rejected.
  function automatic logic stage_legal(input logic [STAGE_W-1:0] code);
    return (code >= STAGE_PRD) && (code <= STAGE_ASSOC);
  endfunction

endpackage

// File: rtl/ekf_cmd_fifo.sv
// Command FIFO for the stage sequencer: registered occupancy count,
// combinational head read, synchronous flush that also drops a same-cycle push.
module ekf_cmd_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic                     ready_o,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against the registered count; flush overrides both.
  always_comb begin
    do_push_s = push_i && (count_q < FULL_CNT) && !flush_i;
    do_pop_s  = pop_i && (count_q != {(AW + 1){1'b0}}) && !flush_i;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW + 1){1'b0}};
    end else if (flush_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW + 1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign ready_o = (count_q < FULL_CNT);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ekf_stage_seq.sv
// Command-driven stage sequencer for the EKF-SLAM Top. Pops queued commands,
// pulses stage_val for PULSE_LEN cycles, then waits for the matching stage_rdy
// or a timeout. Reports latency, done strobes and a sticky error code.
module ekf_stage_seq
  import ekf_pkg::*;
#(
  parameter int ROW_LEN      = 10,
  parameter int TMO_W        = 16,
  parameter int CMD_DEPTH    = 8,
  parameter int PULSE_LEN    = 2,
  parameter int ABORT_ON_TMO = 1
) (
  input  logic                         clk,
  input  logic                         sys_rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [STAGE_W-1:0]           cmd_stage,
  input  logic [ROW_LEN-1:0]           cmd_lk,
  input  logic [TMO_W-1:0]             cmd_tmo,
  input  logic                         run,
  input  logic                         flush,
  input  logic [STAGE_W-1:0]           stage_rdy,
  output logic [STAGE_W-1:0]           stage_val,
  output logic [ROW_LEN-1:0]           l_k,
  output logic                         busy,
  output logic                         stage_done,
  output logic [TMO_W-1:0]             last_lat,
  output logic [$clog2(CMD_DEPTH):0]   fifo_level,
  output logic                         err,
  output logic [1:0]                   err_code
);

  localparam int CMD_W = STAGE_W + ROW_LEN + TMO_W;
  localparam logic [TMO_W-1:0] CNT_MAX   = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0] PULSE_END = TMO_W'(PULSE_LEN - 1);

  seq_state_e          state_q, state_d;
  logic [STAGE_W-1:0]  stage_q, stage_d;
  logic [ROW_LEN-1:0]  lk_q, lk_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic [TMO_W-1:0]    last_lat_q, last_lat_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                done_q, done_d;
  logic                pop_s;
  logic                fifo_flush_s;
  logic [CMD_W-1:0]    head_s;
  logic [STAGE_W-1:0]  head_stage_s;
  logic [ROW_LEN-1:0]  head_lk_s;
  logic [TMO_W-1:0]    head_tmo_s;

  ekf_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (sys_rst),
    .flush_i (fifo_flush_s),
    .push_i  (cmd_valid),
    .wdata_i ({cmd_stage, cmd_lk, cmd_tmo}),
    .ready_o (cmd_ready),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .count_o (fifo_level)
  );

  assign head_stage_s = head_s[CMD_W-1 -: STAGE_W];
  assign head_lk_s    = head_s[TMO_W +: ROW_LEN];
  assign head_tmo_s   = head_s[TMO_W-1:0];

  // FSM state register.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state and datapath: flush wins, completion beats timeout.
  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    lk_d         = lk_q;
    tmo_d        = tmo_q;
    cnt_d        = cnt_q;
    last_lat_d   = last_lat_q;
    err_code_d   = err_code_q;
    done_d       = 1'b0;
    pop_s        = 1'b0;
    fifo_flush_s = 1'b0;
    if (flush) begin
      state_d      = S_IDLE;
      err_code_d   = 2'b00;
      fifo_flush_s = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run && (fifo_level != '0)) begin
            pop_s = 1'b1;
            if (stage_legal(head_stage_s)) begin
              state_d = S_ISSUE;
              stage_d = head_stage_s;
              lk_d    = head_lk_s;
              tmo_d   = head_tmo_s;
              cnt_d   = {TMO_W{1'b0}};
            end else begin
              err_code_d = err_code_q | ERR_ILL;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ISSUE, S_WAIT: begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TMO_W'(1);
          if (stage_rdy == stage_q) begin
            done_d     = 1'b1;
            last_lat_d = cnt_q;
            state_d    = S_IDLE;
          end else if ((tmo_q != {TMO_W{1'b0}}) && (cnt_q == tmo_q)) begin
            err_code_d   = err_code_q | ERR_TMO;
            state_d      = S_IDLE;
            fifo_flush_s = (ABORT_ON_TMO != 0);
          end else if ((state_q == S_ISSUE) && (cnt_q == PULSE_END)) begin
            state_d = S_WAIT;
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath registers: latched command, latency counter, status.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      stage_q    <= IDLE;
      lk_q       <= {ROW_LEN{1'b0}};
      tmo_q      <= {TMO_W{1'b0}};
      cnt_q      <= {TMO_W{1'b0}};
      last_lat_q <= {TMO_W{1'b0}};
      err_code_q <= 2'b00;
      done_q     <= 1'b0;
    end else begin
      stage_q    <= stage_d;
      lk_q       <= lk_d;
      tmo_q      <= tmo_d;
      cnt_q      <= cnt_d;
      last_lat_q <= last_lat_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    stage_val  = (state_q == S_ISSUE) ? stage_q : IDLE;
    busy       = (state_q != S_IDLE);
    l_k        = lk_q;
    stage_done = done_q;
    last_lat   = last_lat_q;
    err_code   = err_code_q;
    err        = |err_code_q;
  end

endmodule
